// File: rtl/cpmg_pkg.sv
// Shared definitions for the CPMG pulse generator and its receive-side
// echo acquisition block.
//   - generator drive levels and default timing (clk cycles at 125 MHz)
//   - acquisition FSM state encoding
//   - accumulator width helper
package cpmg_pkg;

    // Generator drive word levels; the receiver treats any non-zero word as "pulse high".
    localparam logic [15:0] HIGH_VALUE  = 16'h7FFF;
    localparam logic [15:0] LOW_VALUE   = 16'h0000;

    // Default echo timing shared with the generator.
    localparam int          TAU         = 78125;
    localparam int          TWO_TAU     = 2 * TAU;
    localparam int          PULSE_180   = 1000;
    localparam int          TWO_TAU_LOW = TWO_TAU - PULSE_180;

    localparam int          STATE_W     = 4;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE       = 4'd0,
        S_WAIT_90    = 4'd1,
        S_SKIP_90    = 4'd2,
        S_IN_PULSE   = 4'd3,
        S_WAIT_WIN   = 4'd4,
        S_INTEG      = 4'd5,
        S_RESULT     = 4'd6,
        S_WAIT_PULSE = 4'd7,
        S_FINISH     = 4'd8
    } acq_state_t;

    // Smallest accumulator width that cannot wrap over a full window.
    function automatic int sum_w_min(input int adc_w, input int win_len);
        return adc_w + $clog2(win_len);
    endfunction

endpackage

// File: rtl/cpmg_echo_integrator.sv
// Window integrator: sums sign-extended ADC samples while enabled and
// counts how many were taken; stops counting once the window is full.
// Ports:
//   clk, rst      clock, synchronous active-low reset
//   i_clear       zero accumulator and count (window open)
//   i_enable      take i_sample this cycle (ignored once full)
//   i_sample      signed ADC sample
//   o_acc         running two's-complement sum
//   o_count       samples taken in this window
//   o_full        o_count has reached WIN_LEN
module cpmg_echo_integrator
    import cpmg_pkg::*;
#(
    parameter int ADC_W   = 16,
    parameter int SUM_W   = 32,
    parameter int WIN_LEN = 2048,
    parameter int CNT_W   = 18
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clear,
    input  logic             i_enable,
    input  logic [ADC_W-1:0] i_sample,
    output logic [SUM_W-1:0] o_acc,
    output logic [CNT_W-1:0] o_count,
    output logic             o_full
);

    if (SUM_W < sum_w_min(ADC_W, WIN_LEN)) begin : g_sum_w_check
        $error("SUM_W too small for ADC_W and WIN_LEN");
    end

    logic [SUM_W-1:0] r_acc;
    logic [CNT_W-1:0] r_count;
    logic [SUM_W-1:0] w_sample_ext;
    logic             w_full;

    assign w_sample_ext = {{(SUM_W-ADC_W){i_sample[ADC_W-1]}}, i_sample};
    assign w_full       = (r_count == CNT_W'(WIN_LEN));

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_acc   <= '0;
            r_count <= '0;
        end else if (i_clear) begin
            r_acc   <= '0;
            r_count <= '0;
        end else if (i_enable && !w_full) begin
            r_acc   <= r_acc + w_sample_ext;
            r_count <= r_count + 1'b1;
        end
    end

    assign o_acc   = r_acc;
    assign o_count = r_count;
    assign o_full  = w_full;

endmodule

// File: rtl/cpmg_echo_acq.sv
// CPMG echo acquisition: watches the generator drive word, skips the
// excitation pulse, and after each refocusing pulse opens a WIN_LEN-sample
// window WIN_OFFSET cycles after the pulse falls. Each window sum is
// emitted as one result on a valid/ready stream.
// Ports:
//   clk, rst          clock, synchronous active-low reset
//   i_arm, i_n_echo   start strobe and echo count (taken when idle)
//   i_tx_data         generator drive word (non-zero = pulse high)
//   i_adc_data/valid  signed ADC sample and qualifier
//   o_m_sum/idx/last  result stream payload, o_m_valid / i_m_ready handshake
//   o_busy, o_done    train in progress / one-cycle end-of-train strobe
//   o_overflow        sticky: a result was dropped (previous still held)
//   o_early_err       sticky: pulse rose inside an open window
//   o_state           current FSM state
// Stream handshake: a result transfers on a cycle with o_m_valid & i_m_ready.
// o_m_valid stays high with a stable payload until then; it drops the cycle
// after a transfer unless a new result loads in that same cycle.
module cpmg_echo_acq
    import cpmg_pkg::*;
#(
    parameter int ADC_W      = 16,
    parameter int SUM_W      = 32,
    parameter int WIN_OFFSET = 77101,
    parameter int WIN_LEN    = 2048,
    parameter int CNT_W      = 18
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_arm,
    input  logic [15:0]        i_n_echo,
    input  logic [15:0]        i_tx_data,
    input  logic [ADC_W-1:0]   i_adc_data,
    input  logic               i_adc_valid,
    output logic [SUM_W-1:0]   o_m_sum,
    output logic [15:0]        o_m_idx,
    output logic               o_m_last,
    output logic               o_m_valid,
    input  logic               i_m_ready,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_overflow,
    output logic               o_early_err,
    output logic [STATE_W-1:0] o_state
);

    acq_state_t       r_state, w_next;
    logic             r_tx_high, r_tx_q;
    logic [15:0]      r_n_echo, r_echo_cnt;
    logic [CNT_W-1:0] r_off_cnt;
    logic [SUM_W-1:0] r_m_sum;
    logic [15:0]      r_m_idx;
    logic             r_m_last, r_m_valid, r_busy, r_done, r_overflow, r_early_err;

    logic             w_rise, w_fall, w_last_echo;
    logic             w_arm_ok, w_off_clr, w_off_inc, w_win_clr, w_acc_en;
    logic             w_echo_inc, w_load, w_ovf_set, w_early_set, w_finish;
    logic [SUM_W-1:0] w_acc;
    logic [CNT_W-1:0] w_count;
    logic             w_full;

    // Edges are taken between two registered copies of the pulse level,
    // so the FSM sees them one cycle after the drive word changes.
    assign w_rise      = r_tx_high & ~r_tx_q;
    assign w_fall      = ~r_tx_high & r_tx_q;
    assign w_last_echo = (r_echo_cnt == r_n_echo - 16'd1);

    cpmg_echo_integrator #(
        .ADC_W  (ADC_W),
        .SUM_W  (SUM_W),
        .WIN_LEN(WIN_LEN),
        .CNT_W  (CNT_W)
    ) u_integ (
        .clk     (clk),
        .rst     (rst),
        .i_clear (w_win_clr),
        .i_enable(w_acc_en),
        .i_sample(i_adc_data),
        .o_acc   (w_acc),
        .o_count (w_count),
        .o_full  (w_full)
    );

    always_ff @(posedge clk) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next      = r_state;
        w_arm_ok    = 1'b0;
        w_off_clr   = 1'b0;
        w_off_inc   = 1'b0;
        w_win_clr   = 1'b0;
        w_acc_en    = 1'b0;
        w_echo_inc  = 1'b0;
        w_load      = 1'b0;
        w_ovf_set   = 1'b0;
        w_early_set = 1'b0;
        w_finish    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_arm) begin
                    w_arm_ok = 1'b1;
                    if (i_n_echo != 16'd0) w_next = S_WAIT_90;
                end
            end
            S_WAIT_90:    if (w_rise) w_next = S_SKIP_90;
            S_SKIP_90:    if (w_rise) w_next = S_IN_PULSE;
            S_IN_PULSE: begin
                if (w_fall) begin
                    w_off_clr = 1'b1;
                    w_next    = S_WAIT_WIN;
                end
            end
            S_WAIT_WIN: begin
                // A new pulse before the window opens just restarts the wait.
                if (w_rise) begin
                    w_next = S_IN_PULSE;
                end else if (r_off_cnt == CNT_W'(WIN_OFFSET - 1)) begin
                    w_win_clr = 1'b1;
                    w_next    = S_INTEG;
                end else begin
                    w_off_inc = 1'b1;
                end
            end
            S_INTEG: begin
                // A pulse inside the window spends the echo without a result.
                if (w_rise) begin
                    w_early_set = 1'b1;
                    w_echo_inc  = 1'b1;
                    w_next      = w_last_echo ? S_FINISH : S_IN_PULSE;
                end else if (i_adc_valid && !w_full) begin
                    w_acc_en = 1'b1;
                    if (w_count == CNT_W'(WIN_LEN - 1)) w_next = S_RESULT;
                end
            end
            S_RESULT: begin
                if (!r_m_valid || i_m_ready) w_load    = 1'b1;
                else                         w_ovf_set = 1'b1;
                w_echo_inc = 1'b1;
                w_next     = w_last_echo ? S_FINISH : S_WAIT_PULSE;
            end
            S_WAIT_PULSE: if (w_rise) w_next = S_IN_PULSE;
            S_FINISH: begin
                w_finish = 1'b1;
                w_next   = S_IDLE;
            end
            default:      w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_tx_high   <= 1'b0;
            r_tx_q      <= 1'b0;
            r_n_echo    <= '0;
            r_echo_cnt  <= '0;
            r_off_cnt   <= '0;
            r_m_sum     <= '0;
            r_m_idx     <= '0;
            r_m_last    <= 1'b0;
            r_m_valid   <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_overflow  <= 1'b0;
            r_early_err <= 1'b0;
        end else begin
            r_tx_high <= |i_tx_data;
            r_tx_q    <= r_tx_high;
            r_done    <= 1'b0;

            if (w_arm_ok) begin
                r_n_echo    <= i_n_echo;
                r_echo_cnt  <= '0;
                r_overflow  <= 1'b0;
                r_early_err <= 1'b0;
                // An empty train completes immediately without going busy.
                if (i_n_echo == 16'd0) r_done <= 1'b1;
                else                   r_busy <= 1'b1;
            end

            if (w_finish) begin
                r_done <= 1'b1;
                r_busy <= 1'b0;
            end

            if (w_off_clr)      r_off_cnt <= '0;
            else if (w_off_inc) r_off_cnt <= r_off_cnt + 1'b1;

            if (w_echo_inc)  r_echo_cnt  <= r_echo_cnt + 16'd1;
            if (w_early_set) r_early_err <= 1'b1;
            if (w_ovf_set)   r_overflow  <= 1'b1;

            if (w_load) begin
                r_m_sum   <= w_acc;
                r_m_idx   <= r_echo_cnt;
                r_m_last  <= w_last_echo;
                r_m_valid <= 1'b1;
            end else if (i_m_ready) begin
                r_m_valid <= 1'b0;
            end
        end
    end

    assign o_m_sum     = r_m_sum;
    assign o_m_idx     = r_m_idx;
    assign o_m_last    = r_m_last;
    assign o_m_valid   = r_m_valid;
    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_overflow  = r_overflow;
    assign o_early_err = r_early_err;
    assign o_state     = r_state;

endmodule

// File: tb/tb_cpmg_echo_acq.sv
module tb_cpmg_echo_acq;
  import cpmg_pkg::*;

  localparam int ADC_W = 16;
  localparam int SUM_W = 32;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             arm = 1'b0;
  logic [15:0]      n_echo = '0;
  logic [15:0]      tx_data = '0;
  logic [ADC_W-1:0] adc_data = '0;
  logic             adc_valid = 1'b1;
  logic             m_ready = 1'b1;
  logic [SUM_W-1:0] m_sum;
  logic [15:0]      m_idx;
  logic             m_last, m_valid, busy, done, overflow, early_err;
  logic [3:0]       state;

  int n_checks = 0;
  int n_errors = 0;
  int done_cnt = 0;

  // payload = {sum[31:0], idx[15:0], last}
  logic [48:0] exp_q[$];
  logic [48:0] got_q[$];

  bit               const_mode = 1'b0;
  logic [ADC_W-1:0] const_val = '0;

  cpmg_echo_acq #(
    .ADC_W(ADC_W), .SUM_W(SUM_W), .WIN_OFFSET(10), .WIN_LEN(4), .CNT_W(18)
  ) dut (
    .clk(clk), .rst(rst), .i_arm(arm), .i_n_echo(n_echo), .i_tx_data(tx_data),
    .i_adc_data(adc_data), .i_adc_valid(adc_valid),
    .o_m_sum(m_sum), .o_m_idx(m_idx), .o_m_last(m_last), .o_m_valid(m_valid),
    .i_m_ready(m_ready), .o_busy(busy), .o_done(done), .o_overflow(overflow),
    .o_early_err(early_err), .o_state(state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Stream monitor: inputs change at negedge, so #1 later shows what the next posedge samples.
  always begin
    @(negedge clk);
    #1;
    if (rst && m_valid && m_ready) got_q.push_back({m_sum, m_idx, m_last});
    if (rst && done) done_cnt++;
  end

  task automatic compare_results(input string tag);
    check_val({tag, "_n_results"}, 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      check_val({tag, "_sum"},  64'(got_q[i][48:17]), 64'(exp_q[i][48:17]));
      check_val({tag, "_idx"},  64'(got_q[i][16:1]),  64'(exp_q[i][16:1]));
      check_val({tag, "_last"}, 64'(got_q[i][0]),     64'(exp_q[i][0]));
    end
    exp_q.delete();
    got_q.delete();
  endtask

  // ---------------- drivers (entered right after a negedge) ----------------
  task automatic do_arm(input logic [15:0] n);
    arm = 1'b1;
    n_echo = n;
    @(negedge clk);
    arm = 1'b0;
  endtask

  // hi cycles of pulse, then lo cycles low; ramp restarts at 1 with each low period
  task automatic drive_pulse(input int hi, input int lo);
    for (int i = 0; i < hi; i++) begin
      tx_data = HIGH_VALUE;
      adc_data = const_mode ? const_val : '0;
      @(negedge clk);
    end
    for (int i = 0; i < lo; i++) begin
      tx_data = LOW_VALUE;
      adc_data = const_mode ? const_val : ADC_W'(i + 1);
      @(negedge clk);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_m_sum"},  64'(m_sum), 64'd0);
    check_val({tag, "_m_idx"},  64'(m_idx), 64'd0);
    check_val({tag, "_flags"},  64'({m_last, m_valid, busy, done, overflow, early_err}), 64'd0);
    check_val({tag, "_state"},  64'(state), 64'(S_IDLE));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // window: WIN_OFFSET=10 after the fall is seen, so ramp samples 13..16 -> 58
    idle(3);
    check_all_zero("reset");
    rst = 1'b1;
    idle(2);

    // 1: two echoes, ramp
    done_cnt = 0;
    do_arm(16'd2);
    check_val("t1_busy_after_arm", 64'(busy), 64'd1);
    drive_pulse(5, 20);
    drive_pulse(10, 40);
    drive_pulse(10, 40);
    idle(5);
    exp_q.push_back({32'd58, 16'd0, 1'b0});
    exp_q.push_back({32'd58, 16'd1, 1'b1});
    compare_results("t1");
    check_val("t1_done_cnt", 64'(done_cnt), 64'd1);
    check_val("t1_busy_end", 64'(busy), 64'd0);
    check_val("t1_flags", 64'({overflow, early_err}), 64'd0);

    // 2: constant negative and full-scale samples
    const_mode = 1'b1;
    const_val = 16'hFFFD;
    do_arm(16'd1);
    drive_pulse(5, 20);
    drive_pulse(10, 40);
    idle(3);
    exp_q.push_back({32'hFFFF_FFF4, 16'd0, 1'b1});
    compare_results("t2_neg");
    const_val = 16'h7FFF;
    do_arm(16'd1);
    drive_pulse(5, 20);
    drive_pulse(10, 40);
    idle(3);
    exp_q.push_back({32'h0001_FFFC, 16'd0, 1'b1});
    compare_results("t2_max");
    const_mode = 1'b0;

    // 3: downstream stalled across two echoes
    m_ready = 1'b0;
    do_arm(16'd2);
    drive_pulse(5, 20);
    drive_pulse(10, 40);
    drive_pulse(10, 40);
    idle(3);
    check_val("t3_overflow", 64'(overflow), 64'd1);
    check_val("t3_held_valid", 64'(m_valid), 64'd1);
    check_val("t3_held_idx", 64'(m_idx), 64'd0);
    check_val("t3_held_sum", 64'(m_sum), 64'd58);
    m_ready = 1'b1;
    idle(4);
    exp_q.push_back({32'd58, 16'd0, 1'b0});
    compare_results("t3");
    check_val("t3_valid_drop", 64'(m_valid), 64'd0);

    // 4: pulse rises 2 clk into the window (12-cycle low period)
    do_arm(16'd2);
    check_val("t4_sticky_cleared", 64'({overflow, early_err}), 64'd0);
    drive_pulse(5, 20);
    drive_pulse(10, 12);
    drive_pulse(10, 40);
    idle(3);
    exp_q.push_back({32'd58, 16'd1, 1'b1});
    compare_results("t4");
    check_val("t4_early_err", 64'(early_err), 64'd1);
    check_val("t4_overflow", 64'(overflow), 64'd0);

    // 5: empty train, then arm while busy
    done_cnt = 0;
    do_arm(16'd0);
    check_val("t5_done_next", 64'(done), 64'd1);
    check_val("t5_busy_never", 64'(busy), 64'd0);
    check_val("t5_early_cleared", 64'(early_err), 64'd0);
    idle(1);
    check_val("t5_done_one_cycle", 64'(done), 64'd0);
    check_val("t5_busy_still_low", 64'(busy), 64'd0);
    do_arm(16'd1);
    drive_pulse(5, 20);
    do_arm(16'd5);
    check_val("t5_busy_on_rearm", 64'(busy), 64'd1);
    drive_pulse(10, 40);
    idle(3);
    exp_q.push_back({32'd58, 16'd0, 1'b1});
    compare_results("t5");
    check_val("t5_done_cnt", 64'(done_cnt), 64'd2);
    check_val("t5_busy_end", 64'(busy), 64'd0);

    // 6: reset while integrating, then a clean train
    do_arm(16'd2);
    drive_pulse(5, 20);
    drive_pulse(10, 14);
    check_val("t6_in_integ", 64'(state), 64'(S_INTEG));
    rst = 1'b0;
    @(negedge clk);
    check_all_zero("t6_rst");
    rst = 1'b1;
    idle(2);
    done_cnt = 0;
    do_arm(16'd2);
    drive_pulse(5, 20);
    drive_pulse(10, 40);
    drive_pulse(10, 40);
    idle(5);
    exp_q.push_back({32'd58, 16'd0, 1'b0});
    exp_q.push_back({32'd58, 16'd1, 1'b1});
    compare_results("t6");
    check_val("t6_done_cnt", 64'(done_cnt), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
